config_sequencer: RTL and testbench

Streams a configuration bitstream into the tile array's shared `config_addr`/`config_data` bus. Words arrive on a valid/ready input stream. Each addressed write is presented to the tiles for exactly one cycle, so the SB/CB/CLB config enables fire once per word. The whole load is validated with a header count and an XOR checksum trailer. The block sits between the off-chip loader and the top of the PE tile grid, and is the only driver of the config bus.

---
 rtl/config_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_config_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_sequencer.sv
// config_sequencer
//   Streams a configuration bitstream from a valid/ready word stream onto the
//   tile array's shared config bus. Load format: header (pair count in [15:0]),
//   count x {addr, data}, then an XOR checksum trailer over all addr/data words.
//   Each write appears on the bus for exactly one cycle.
//
// Ports
//   clk           : rising-edge clock
//   reset         : asynchronous active-low reset
//   start         : begin a load (honoured only while idle)
//   in_data       : bitstream word
//   in_valid      : in_data valid
//   in_ready      : word accepted this cycle when in_valid is also high
//   config_addr   : {target[31:16], tile_id[15:0]}, IDLE_ADDR when no write
//   config_data   : write data, 0 when no write
//   config_strobe : high for the single cycle a write is on the bus
//   busy          : load in progress
//   done          : one-cycle pulse on a successful load
//   error         : sticky load error, cleared by the next accepted start
//   write_count   : writes issued in the current or last load
module config_sequencer #(
    parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
    parameter int unsigned MAX_COUNT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_strobe,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] write_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] csum_q, csum_d;
    logic [31:0] config_addr_q, config_addr_d;
    logic [31:0] config_data_q, config_data_d;
    logic        config_strobe_q, config_strobe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] write_count_q, write_count_d;

    logic        xfer;
    logic [15:0] hdr_count;
    logic        hdr_bad;

    // in_ready is the only output decoded directly from state
    assign in_ready  = (state_q == S_HDR) || (state_q == S_ADDR) ||
                       (state_q == S_DATA) || (state_q == S_CHK);
    assign xfer      = in_valid && in_ready;
    assign hdr_count = in_data[15:0];
    assign hdr_bad   = (hdr_count == 16'd0) || (32'(hdr_count) > MAX_COUNT);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        csum_d          = csum_q;
        error_d         = error_q;
        write_count_d   = write_count_q;
        // Bus defaults to idle; only an accepted data word drives a write,
        // so stalls and the cycle after WRITE leave it idle automatically.
        config_addr_d   = IDLE_ADDR;
        config_data_d   = '0;
        config_strobe_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_HDR;
                    error_d       = 1'b0;
                    write_count_d = '0;
                    remaining_d   = '0;
                    csum_d        = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (hdr_bad) begin
                        state_d = S_ERR;
                    end else begin
                        remaining_d = hdr_count;
                        state_d     = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (xfer) begin
                    addr_d  = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d          = csum_q ^ in_data;
                    config_addr_d   = addr_q;
                    config_data_d   = in_data;
                    config_strobe_d = 1'b1;
                    state_d         = S_WRITE;
                end
            end
            S_WRITE: begin
                write_count_d = write_count_q + 16'd1;
                remaining_d   = remaining_q - 16'd1;
                state_d       = (remaining_q == 16'd1) ? S_CHK : S_ADDR;
            end
            S_CHK: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            csum_q          <= '0;
            config_addr_q   <= IDLE_ADDR;
            config_data_q   <= '0;
            config_strobe_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            write_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            csum_q          <= csum_d;
            config_addr_q   <= config_addr_d;
            config_data_q   <= config_data_d;
            config_strobe_q <= config_strobe_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            write_count_q   <= write_count_d;
        end
    end

    assign config_addr   = config_addr_q;
    assign config_data   = config_data_q;
    assign config_strobe = config_strobe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign write_count   = write_count_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Bench for config_sequencer: stimulus pushes expected writes, load outcomes
// and per-cycle probes into queues; a negedge monitor pops and compares.
module tb_config_sequencer;

    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;
    localparam int          MAXC      = 1024;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] in_data  = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_strobe;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] write_count;

    always #5 clk = ~clk;

    config_sequencer #(
        .IDLE_ADDR (IDLE_ADDR),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .config_strobe (config_strobe),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .write_count   (write_count)
    );

    typedef enum int {K_WCNT, K_ERR, K_BUSY, K_RDY, K_ADDR, K_DATA, K_STB, K_DONE, K_QEMPTY, K_TMO} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } probe_t;

    probe_t      probes[$];
    logic [63:0] exp_wr[$];   // {addr, data} in issue order
    int          exp_out[$];  // 1 = done, 2 = error

    int     n_checks = 0;
    int     n_fail   = 0;
    bit     spacing_mode = 1'b0;
    int     cyc = 0;
    int     last_stb = -1;
    logic   prev_stb = 1'b0;
    logic   prev_err = 1'b0;
    probe_t mon_p;
    logic [63:0] mon_w;
    int     mon_o;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        while (probes.size() > 0) begin
            mon_p = probes.pop_front();
            case (mon_p.kind)
                K_WCNT:   chk(mon_p.name, {16'h0, write_count}, mon_p.exp);
                K_ERR:    chk(mon_p.name, {31'h0, error}, mon_p.exp);
                K_BUSY:   chk(mon_p.name, {31'h0, busy}, mon_p.exp);
                K_RDY:    chk(mon_p.name, {31'h0, in_ready}, mon_p.exp);
                K_ADDR:   chk(mon_p.name, config_addr, mon_p.exp);
                K_DATA:   chk(mon_p.name, config_data, mon_p.exp);
                K_STB:    chk(mon_p.name, {31'h0, config_strobe}, mon_p.exp);
                K_DONE:   chk(mon_p.name, {31'h0, done}, mon_p.exp);
                K_QEMPTY: chk(mon_p.name, 32'(exp_wr.size() + exp_out.size()), mon_p.exp);
                default: begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: handshake not accepted within bound, required acceptance", mon_p.name);
                end
            endcase
        end

        if (!spacing_mode) last_stb = -1;

        if (config_strobe) begin
            chk("strobe_single_cycle", {31'h0, prev_stb}, 32'h0);
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got addr 0x%08h data 0x%08h required no write", config_addr, config_data);
            end else begin
                mon_w = exp_wr.pop_front();
                chk("write_addr", config_addr, mon_w[63:32]);
                chk("write_data", config_data, mon_w[31:0]);
            end
            if (spacing_mode && last_stb >= 0) chk("strobe_spacing", 32'(cyc - last_stb), 32'd3);
            last_stb = cyc;
        end else begin
            chk("bus_idle", {config_addr ^ IDLE_ADDR} | config_data, 32'h0);
        end

        if (done) begin
            if (exp_out.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no outcome");
            end else begin
                mon_o = exp_out.pop_front();
                chk("outcome_done", 32'd1, 32'(mon_o));
            end
        end
        if (error && !prev_err) begin
            if (exp_out.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_error: got error rise required no outcome");
            end else begin
                mon_o = exp_out.pop_front();
                chk("outcome_error", 32'd2, 32'(mon_o));
            end
        end
        prev_stb = config_strobe;
        prev_err = error;
    end

    // ---------------- stimulus ----------------
    task automatic probe(kind_e k, logic [31:0] e, string n);
        probes.push_back('{kind: k, exp: e, name: n});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(logic [31:0] w, int gap, string nm);
        bit hs;
        int budget;
        if (gap > 0) begin
            in_valid = 1'b0;
            idle(gap);
        end
        in_valid = 1'b1;
        in_data  = w;
        hs       = 1'b0;
        budget   = 0;
        while (!hs && budget <= 100) begin
            hs = in_ready;
            tick();
            budget++;
        end
        if (!hs) probe(K_TMO, 32'h0, nm);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int gapof(bit gaps, int k);
        return gaps ? ((k * 5 + 3) % 4) : 0;
    endfunction

    task automatic load(int n, int seed, bit gaps, bit bad_trl, bit poke);
        logic [31:0] cs;
        logic [31:0] a;
        logic [31:0] d;
        int          k;
        cs = '0;
        k  = 0;
        exp_out.push_back(bad_trl ? 2 : 1);
        send(32'(n), gapof(gaps, k++), "hdr");
        if (poke) begin
            // start while busy must be ignored
            in_valid = 1'b0;
            start    = 1'b1;
            tick();
            start    = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            a  = {16'(4 + (i + seed) % 4), 16'(seed * 256 + i)};
            d  = {8'(seed), 8'(i), 16'(i * 40503 + 7)};
            cs = cs ^ a ^ d;
            exp_wr.push_back({a, d});
            send(a, gapof(gaps, k++), "addr");
            send(d, gapof(gaps, k++), "data");
        end
        send(bad_trl ? (cs ^ 32'h1) : cs, gapof(gaps, k++), "trailer");
    endtask

    // called in the cycle after the trailer was accepted
    task automatic expect_done(int wc);
        probe(K_DONE, 32'd1, "done_pulse");
        probe(K_BUSY, 32'd1, "busy_in_done");
        tick();
        probe(K_DONE, 32'd0, "done_cleared");
        probe(K_BUSY, 32'd0, "busy_after_done");
        probe(K_WCNT, 32'(wc), "write_count");
        probe(K_ERR,  32'd0, "no_error");
    endtask

    task automatic expect_err(int wc);
        probe(K_ERR,  32'd0, "error_not_yet");
        probe(K_DONE, 32'd0, "no_done_on_err");
        probe(K_RDY,  32'd0, "ready_drops");
        tick();
        probe(K_ERR,  32'd1, "error_set");
        probe(K_BUSY, 32'd0, "busy_after_err");
        probe(K_WCNT, 32'(wc), "write_count_err");
    endtask

    initial begin
        // reset values
        idle(2);
        probe(K_ADDR, IDLE_ADDR, "rst_addr");
        probe(K_DATA, 32'h0, "rst_data");
        probe(K_STB,  32'h0, "rst_strobe");
        probe(K_BUSY, 32'h0, "rst_busy");
        probe(K_DONE, 32'h0, "rst_done");
        probe(K_ERR,  32'h0, "rst_error");
        probe(K_WCNT, 32'h0, "rst_wcnt");
        probe(K_RDY,  32'h0, "rst_ready");
        tick();
        reset = 1'b1;
        idle(2);

        // single write
        do_start();
        probe(K_BUSY, 32'd1, "busy_after_start");
        probe(K_RDY,  32'd1, "ready_after_start");
        exp_out.push_back(1);
        send(32'd1, 0, "hdr1");
        exp_wr.push_back({32'h0007_0003, 32'h0000_0005});
        send(32'h0007_0003, 0, "addr1");
        send(32'h0000_0005, 0, "data1");
        send(32'h0007_0006, 0, "trl1");
        expect_done(1);
        in_valid = 1'b0;
        idle(2);

        // back-to-back, count 3
        spacing_mode = 1'b1;
        do_start();
        load(3, 1, 1'b0, 1'b0, 1'b0);
        expect_done(3);
        spacing_mode = 1'b0;
        in_valid = 1'b0;
        idle(2);

        // 16 pairs with in_valid gaps
        do_start();
        load(16, 2, 1'b1, 1'b0, 1'b0);
        expect_done(16);
        in_valid = 1'b0;
        idle(2);

        // checksum mismatch
        do_start();
        load(2, 3, 1'b0, 1'b1, 1'b0);
        expect_err(2);
        in_valid = 1'b0;
        idle(2);

        // illegal header: count 0, words held valid are not consumed
        do_start();
        probe(K_ERR, 32'd0, "start_clears_error");
        exp_out.push_back(2);
        send(32'd0, 0, "hdr_zero");
        expect_err(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            probe(K_RDY, 32'd0, "not_consumed");
        end
        in_valid = 1'b0;
        idle(1);

        // illegal header: MAX_COUNT+1
        do_start();
        exp_out.push_back(2);
        send(32'(MAXC + 1), 0, "hdr_over");
        expect_err(0);
        in_valid = 1'b0;
        idle(2);

        // largest legal header
        do_start();
        load(MAXC, 5, 1'b0, 1'b0, 1'b0);
        expect_done(MAXC);
        in_valid = 1'b0;
        idle(2);

        // reset during the WRITE cycle of pair 2 of 4
        do_start();
        send(32'd4, 0, "hdr_rst");
        exp_wr.push_back({32'h0005_0101, 32'hCAFE_0001});
        send(32'h0005_0101, 0, "addr_rst1");
        send(32'hCAFE_0001, 0, "data_rst1");
        send(32'h0006_0102, 0, "addr_rst2");
        send(32'hCAFE_0002, 0, "data_rst2");
        reset    = 1'b0;
        in_valid = 1'b0;
        probe(K_STB,  32'd0, "rst_mid_strobe");
        probe(K_ADDR, IDLE_ADDR, "rst_mid_addr");
        probe(K_DATA, 32'd0, "rst_mid_data");
        probe(K_BUSY, 32'd0, "rst_mid_busy");
        probe(K_RDY,  32'd0, "rst_mid_ready");
        probe(K_WCNT, 32'd0, "rst_mid_wcnt");
        idle(2);
        reset = 1'b1;
        idle(1);

        // fresh load with a start pulse while busy
        do_start();
        load(2, 6, 1'b0, 1'b0, 1'b1);
        expect_done(2);
        in_valid = 1'b0;
        idle(3);
        probe(K_QEMPTY, 32'd0, "scoreboard_drained");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1);
    end

endmodule
